os_framer_ovl: RTL
==================

Name: os_framer_ovl

Overview:
- Generalised overlap-save input framer for the frequency-domain equaliser path.
- Accepts a continuous complex I/Q sample stream with ready/valid input handshake.
- Emits NFFT-sample frames to the FFT: the last NFFT-NHOP previously received samples followed by NHOP new samples.
- Overlap is parametrised (not fixed at 50%). Supports downstream backpressure and accepts the next hop while the current frame is being emitted.

Parameters:
- NFFT, 32, frame length delivered to FFT (>=2).
- NHOP, 16, new samples per frame; 1 <= NHOP <= NFFT; overlap = NFFT-NHOP.
- WN, 9, sample width (signed, per I and Q).
- WCNT, 16, frame counter width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  input sample valid
- i_xI  in  WN  input I sample (signed)
- i_xQ  in  WN  input Q sample (signed)
- o_in_ready  out  1  framer can accept a sample this cycle
- o_drop  out  1  one-cycle pulse: i_valid seen while o_in_ready=0; sample discarded
- i_fft_ready  in  1  downstream accepts current output beat
- o_fft_valid  out  1  output beat valid
- o_fft_start  out  1  first beat of frame (qualified by o_fft_valid)
- o_fft_last  out  1  last beat of frame (qualified by o_fft_valid)
- o_fft_xI  out  WN  output I
- o_fft_xQ  out  WN  output Q
- o_frame_cnt  out  WCNT  completed frames, wraps modulo 2^WCNT

Behaviour:
- Storage: circular register array, depth D = NFFT+NHOP, I and Q. Write pointer wp is mod D, width clog2(D).
- Reset clears the whole array to 0, so the first frame's overlap region is zeros.
- Reset values: wp=0, cnt_new=0, state IDLE, o_in_ready=1, all other outputs 0, o_frame_cnt=0.
- Reset mid-frame aborts immediately; no partial frame completes.
- Input handshake:
  - A sample is accepted on a posedge with i_valid && o_in_ready.
  - It is written to mem[wp]; wp advances by 1 mod D; cnt_new increments.
- o_in_ready = (cnt_new != NHOP), registered-equivalent. Once a hop is complete, input stalls until that hop's frame is launched.
- At launch, cnt_new clears to 0. Up to NHOP further samples may be accepted while the frame emits. D = NFFT+NHOP guarantees these never overwrite the active frame.
- o_drop: combinational pulse, i_valid && !o_in_ready. Internal state is unaffected.
- FSM has two states, IDLE and RUN.
  - IDLE -> RUN at the posedge where the registered cnt_new==NHOP.
  - At that edge: read base rb = wp - NFFT (mod D); cnt_new cleared; o_fft_xI/Q loaded with mem[rb]; o_fft_valid=1; o_fft_start=1.
- Latency: NHOP-th sample of a hop accepted at edge k -> o_fft_valid high after edge k+1.
- RUN, beat index b (0..NFFT-1):
  - A beat transfers on posedge with o_fft_valid && i_fft_ready.
  - On transfer, b++ and the output is loaded with mem[rb+b] mod D.
  - With no transfer, outputs hold stable, including start/last.
- o_fft_start=1 only at b=0; o_fft_last=1 only at b=NFFT-1.
- On the last transfer, o_frame_cnt increments.
  - If cnt_new==NHOP before that edge: the next frame launches at the same edge, with zero bubble and o_fft_start=1.
  - Otherwise go to IDLE with o_fft_valid=0.
- Simultaneous events:
  - NHOP-th input accepted on the same edge as the last transfer: the launch decision uses pre-edge cnt_new, so exactly one idle cycle follows, then launch.
  - Input acceptance and output transfer on the same edge are independent.
- Output is purely registered; no combinational path from i_fft_ready to outputs.
- NHOP==NFFT: no overlap, plain block framer; depth is 2*NFFT.

Test Plan:
- NFFT=16, NHOP=8, i_fft_ready=1, blocks Bf[k]=(10f+7+3k, 10f+7-2k-1) for f=0..4, k=0..7:
  - frame f = Bf-1[8..15 data] || Bf, with B-1 = zeros.
  - o_fft_valid high for exactly 16 cycles; start/last on beats 0 and 15; o_frame_cnt ends at 5.
- NFFT=16, NHOP=4 (75% overlap), stream ramp 1,2,3,...:
  - frame n = samples 4n-11..4n+4, values <=0 index replaced by 0 (frame 0 = 12 zeros, then 1..4).
- Backpressure: i_fft_ready random 50% while input streams continuously:
  - o_fft_* held stable whenever valid && !ready.
  - o_in_ready drops after NHOP lookahead samples; no mismatch, no sample lost.
- Zero-bubble: input saturated, ready=1, NHOP=8:
  - o_fft_valid stays high across frame boundaries after the first frame; start follows last directly.
- Violation: drive i_valid=1 while o_in_ready=0 -> o_drop pulses each such cycle; the following frame's data is unaffected.
- Reset at beat 5 of frame 2 -> all outputs 0 next cycle; next frame's overlap region is all zeros; o_frame_cnt=0.

Source files
------------

// File: rtl/os_framer_ovl.sv
// Overlap-save input framer: buffers a complex sample stream and emits NFFT-sample
// frames made of the previous NFFT-NHOP samples followed by NHOP fresh ones.
module os_framer_ovl #(
  parameter int NFFT = 32,
  parameter int NHOP = 16,
  parameter int WN   = 9,
  parameter int WCNT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic signed [WN-1:0] i_xI,
  input  logic signed [WN-1:0] i_xQ,
  output logic                 o_in_ready,
  output logic                 o_drop,
  input  logic                 i_fft_ready,
  output logic                 o_fft_valid,
  output logic                 o_fft_start,
  output logic                 o_fft_last,
  output logic signed [WN-1:0] o_fft_xI,
  output logic signed [WN-1:0] o_fft_xQ,
  output logic [WCNT-1:0]      o_frame_cnt
);

  localparam int D  = NFFT + NHOP;
  localparam int WP = $clog2(D);
  localparam int WC = $clog2(NHOP + 1);
  localparam int WB = $clog2(NFFT);

  localparam logic [WP-1:0] NFFT_P  = WP'(NFFT);
  localparam logic [WP-1:0] NHOP_P  = WP'(NHOP);
  localparam logic [WP-1:0] DM1_P   = WP'(D - 1);
  localparam logic [WC-1:0] NHOP_C  = WC'(NHOP);
  localparam logic [WB-1:0] LAST_M1 = WB'(NFFT - 2);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state_r, state_s;
  logic signed [WN-1:0]  mem_i_r [D];
  logic signed [WN-1:0]  mem_q_r [D];
  logic [WP-1:0]         wp_r, rp_r, rb_s;
  logic [WC-1:0]         cnt_new_r;
  logic [WB-1:0]         b_r;
  logic                  accept_s, xfer_s, last_xfer_s, hop_full_s, launch_s;

  function automatic logic [WP-1:0] ptr_inc(input logic [WP-1:0] p);
    ptr_inc = (p == DM1_P) ? WP'(0) : p + WP'(1);
  endfunction

  assign hop_full_s  = (cnt_new_r == NHOP_C);
  assign o_in_ready  = !hop_full_s;
  assign o_drop      = i_valid && hop_full_s;
  assign accept_s    = i_valid && !hop_full_s;
  assign xfer_s      = o_fft_valid && i_fft_ready;
  assign last_xfer_s = xfer_s && o_fft_last;

  // Frame read base: NFFT samples behind the write pointer, modulo D.
  always_comb begin
    if (wp_r >= NFFT_P) begin
      rb_s = wp_r - NFFT_P;
    end else begin
      rb_s = wp_r + NHOP_P;
    end
  end

  // Next-state and launch decision, both from pre-edge hop count.
  always_comb begin
    state_s  = state_r;
    launch_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (hop_full_s) begin
          launch_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (last_xfer_s) begin
          launch_s = hop_full_s;
          state_s  = hop_full_s ? RUN : IDLE;
        end else begin
          state_s  = RUN;
        end
      end
      default: begin
        state_s  = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Sample store; cleared on reset so the first frame's overlap reads as zeros.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < D; k++) begin
        mem_i_r[k] <= {WN{1'b0}};
        mem_q_r[k] <= {WN{1'b0}};
      end
    end else if (accept_s) begin
      mem_i_r[wp_r] <= i_xI;
      mem_q_r[wp_r] <= i_xQ;
    end
  end

  // Write pointer and count of new samples in the pending hop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wp_r      <= WP'(0);
      cnt_new_r <= WC'(0);
    end else begin
      if (accept_s) wp_r <= ptr_inc(wp_r);
      if (launch_s)      cnt_new_r <= WC'(0);
      else if (accept_s) cnt_new_r <= cnt_new_r + WC'(1);
    end
  end

  // Registered output beat, read pointer and beat index.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_fft_valid <= 1'b0;
      o_fft_start <= 1'b0;
      o_fft_last  <= 1'b0;
      o_fft_xI    <= {WN{1'b0}};
      o_fft_xQ    <= {WN{1'b0}};
      rp_r        <= WP'(0);
      b_r         <= WB'(0);
    end else if (launch_s) begin
      o_fft_valid <= 1'b1;
      o_fft_start <= 1'b1;
      o_fft_last  <= 1'b0;
      o_fft_xI    <= mem_i_r[rb_s];
      o_fft_xQ    <= mem_q_r[rb_s];
      rp_r        <= ptr_inc(rb_s);
      b_r         <= WB'(0);
    end else if (last_xfer_s) begin
      o_fft_valid <= 1'b0;
      o_fft_start <= 1'b0;
      o_fft_last  <= 1'b0;
    end else if (xfer_s) begin
      o_fft_start <= 1'b0;
      o_fft_last  <= (b_r == LAST_M1);
      o_fft_xI    <= mem_i_r[rp_r];
      o_fft_xQ    <= mem_q_r[rp_r];
      rp_r        <= ptr_inc(rp_r);
      b_r         <= b_r + WB'(1);
    end
  end

  // Completed-frame counter.
  always_ff @(posedge i_clk) begin
    if (i_rst)            o_frame_cnt <= WCNT'(0);
    else if (last_xfer_s) o_frame_cnt <= o_frame_cnt + WCNT'(1);
  end

endmodule
